// File: rtl/cache_tag_writer.sv
// Write/allocate side of a set-associative tag store with a per-set tree PLRU.
// Optional hit/alloc/evict counters are enabled by defining CACHE_WRITER_STATS_EN.
module cache_tag_writer #(
  parameter int WAYS_REP = 3,
  parameter int INDEX    = 3,
  parameter int TAG_W    = 12
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                wr_req,
  input  logic [INDEX-1:0]    wr_index,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic                wr_dirty,
  output logic                wr_ready,
  output logic                wr_ack,
  output logic [WAYS_REP-1:0] wr_way,
  output logic                wr_hit,
  output logic                evict_valid,
  output logic [TAG_W-1:0]    evict_tag,
`ifdef CACHE_WRITER_STATS_EN
  output logic [15:0]         stat_hits,
  output logic [15:0]         stat_allocs,
  output logic [15:0]         stat_evicts,
`endif
  input  logic [INDEX-1:0]    rd_index,
  input  logic [WAYS_REP-1:0] rd_way,
  output logic [TAG_W-1:0]    rd_tag,
  output logic                rd_valid,
  output logic                rd_dirty
);

  localparam int WAYS = 2 ** WAYS_REP;
  localparam int SETS = 2 ** INDEX;

  typedef enum logic [1:0] {IDLE, SCAN, WRITE} state_t;

  state_t               state_reg, state_next;
  logic [WAYS_REP:0]    cntr_reg, cntr_next;
  logic [WAYS_REP-1:0]  way_reg, way_next;
  logic                 hit_reg, hit_next;
  logic                 inv_found_reg, inv_found_next;
  logic [WAYS_REP-1:0]  inv_way_reg, inv_way_next;
  logic [INDEX-1:0]     idx_reg;
  logic [TAG_W-1:0]     req_tag_reg;
  logic                 req_dirty_reg;

  logic [TAG_W-1:0]     tag_mem   [SETS][WAYS];
  logic [WAYS-1:0]      valid_mem [SETS];
  logic [WAYS-1:0]      dirty_mem [SETS];
  logic [WAYS-2:0]      plru_mem  [SETS];

  logic [WAYS_REP-1:0]  cur_way, victim_way, node, node_upd;
  logic                 cur_valid, old_valid, old_dirty, new_dirty, bit_v, dir_v;
  logic [TAG_W-1:0]     cur_tag, old_tag;
  logic [WAYS-2:0]      plru_row, plru_new;

  assign cur_way   = cntr_reg[WAYS_REP-1:0];
  assign cur_valid = valid_mem[idx_reg][cur_way];
  assign cur_tag   = tag_mem[idx_reg][cur_way];
  assign old_valid = valid_mem[idx_reg][way_reg];
  assign old_dirty = dirty_mem[idx_reg][way_reg];
  assign old_tag   = tag_mem[idx_reg][way_reg];
  assign new_dirty = hit_reg ? (old_dirty | req_dirty_reg) : req_dirty_reg;

  // Victim walk from the root, and the path update pointing every node away from way_reg.
  always_comb begin
    plru_row   = plru_mem[idx_reg];
    plru_new   = plru_row;
    victim_way = '0;
    node       = '0;
    node_upd   = '0;
    bit_v      = 1'b0;
    dir_v      = 1'b0;
    for (int l = 0; l < WAYS_REP; l++) begin
      bit_v = plru_row[node];
      victim_way[WAYS_REP-1-l] = bit_v;
      node = {node[WAYS_REP-2:0], 1'b1} + {{(WAYS_REP-1){1'b0}}, bit_v};
      dir_v = way_reg[WAYS_REP-1-l];
      plru_new[node_upd] = ~dir_v;
      node_upd = {node_upd[WAYS_REP-2:0], 1'b1} + {{(WAYS_REP-1){1'b0}}, dir_v};
    end
  end

  always_comb begin
    state_next     = state_reg;
    cntr_next      = cntr_reg;
    way_next       = way_reg;
    hit_next       = hit_reg;
    inv_found_next = inv_found_reg;
    inv_way_next   = inv_way_reg;
    case (state_reg)
      IDLE: if (wr_req) begin
        state_next     = SCAN;
        cntr_next      = '0;
        hit_next       = 1'b0;
        inv_found_next = 1'b0;
        inv_way_next   = '0;
      end
      SCAN: if (cur_valid && (cur_tag == req_tag_reg)) begin
        state_next = WRITE;
        way_next   = cur_way;
        hit_next   = 1'b1;
      end else begin
        if (!cur_valid && !inv_found_reg) begin
          inv_found_next = 1'b1;
          inv_way_next   = cur_way;
        end
        if (cntr_reg == (WAYS_REP+1)'(WAYS - 1)) begin
          state_next = WRITE;
          hit_next   = 1'b0;
          way_next   = inv_found_reg ? inv_way_reg : (!cur_valid ? cur_way : victim_way);
        end else begin
          cntr_next = cntr_reg + 1'b1;
        end
      end
      WRITE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg     <= IDLE;
      cntr_reg      <= '0;
      way_reg       <= '0;
      hit_reg       <= 1'b0;
      inv_found_reg <= 1'b0;
      inv_way_reg   <= '0;
      idx_reg       <= '0;
      req_tag_reg   <= '0;
      req_dirty_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cntr_reg      <= cntr_next;
      way_reg       <= way_next;
      hit_reg       <= hit_next;
      inv_found_reg <= inv_found_next;
      inv_way_reg   <= inv_way_next;
      if (state_reg == IDLE && wr_req) begin
        idx_reg       <= wr_index;
        req_tag_reg   <= wr_tag;
        req_dirty_reg <= wr_dirty;
      end
    end
  end

  // Tags need no reset: valid=0 masks them everywhere they are consumed.
  always_ff @(posedge clk) begin
    if (state_reg == WRITE) tag_mem[idx_reg][way_reg] <= req_tag_reg;
  end

  for (genvar gi = 0; gi < SETS; gi++) begin : g_set
    logic            set_we;
    logic [WAYS-1:0] valid_reg, dirty_reg;
    logic [WAYS-2:0] plru_reg;
    assign set_we = (state_reg == WRITE) && (idx_reg == INDEX'(gi));
    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        valid_reg <= '0;
        dirty_reg <= '0;
        plru_reg  <= '0;
      end else if (set_we) begin
        valid_reg[way_reg] <= 1'b1;
        dirty_reg[way_reg] <= new_dirty;
        plru_reg           <= plru_new;
      end
    end
    assign valid_mem[gi] = valid_reg;
    assign dirty_mem[gi] = dirty_reg;
    assign plru_mem[gi]  = plru_reg;
  end

  assign wr_ready    = (state_reg == IDLE);
  assign wr_ack      = (state_reg == WRITE);
  assign wr_way      = wr_ack ? way_reg : '0;
  assign wr_hit      = wr_ack & hit_reg;
  assign evict_valid = wr_ack & ~hit_reg & old_valid & old_dirty;
  assign evict_tag   = wr_ack ? old_tag : '0;

  assign rd_tag   = tag_mem[rd_index][rd_way];
  assign rd_valid = valid_mem[rd_index][rd_way];
  assign rd_dirty = dirty_mem[rd_index][rd_way];

`ifdef CACHE_WRITER_STATS_EN
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      stat_hits   <= '0;
      stat_allocs <= '0;
      stat_evicts <= '0;
    end else if (wr_ack) begin
      if (hit_reg && stat_hits != 16'hFFFF) stat_hits <= stat_hits + 16'd1;
      if (!hit_reg && stat_allocs != 16'hFFFF) stat_allocs <= stat_allocs + 16'd1;
      if (evict_valid && stat_evicts != 16'hFFFF) stat_evicts <= stat_evicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_tag_writer.sv
// Directed, table-driven bench for cache_tag_writer (default 8 ways, 8 sets, 12-bit tags).
module tb_cache_tag_writer;

  logic        clk = 1'b0;
  logic        rstb;
  logic        wr_req;
  logic [2:0]  wr_index;
  logic [11:0] wr_tag;
  logic        wr_dirty;
  logic        wr_ready, wr_ack, wr_hit, evict_valid;
  logic [2:0]  wr_way;
  logic [11:0] evict_tag;
  logic [2:0]  rd_index, rd_way;
  logic [11:0] rd_tag;
  logic        rd_valid, rd_dirty;
`ifdef CACHE_WRITER_STATS_EN
  logic [15:0] stat_hits, stat_allocs, stat_evicts;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cache_tag_writer dut (
    .clk(clk), .rstb(rstb),
    .wr_req(wr_req), .wr_index(wr_index), .wr_tag(wr_tag), .wr_dirty(wr_dirty),
    .wr_ready(wr_ready), .wr_ack(wr_ack), .wr_way(wr_way), .wr_hit(wr_hit),
    .evict_valid(evict_valid), .evict_tag(evict_tag),
`ifdef CACHE_WRITER_STATS_EN
    .stat_hits(stat_hits), .stat_allocs(stat_allocs), .stat_evicts(stat_evicts),
`endif
    .rd_index(rd_index), .rd_way(rd_way),
    .rd_tag(rd_tag), .rd_valid(rd_valid), .rd_dirty(rd_dirty)
  );

  typedef struct {
    logic [2:0]  idx;
    logic [11:0] tag;
    logic        dirty;
    logic [2:0]  way;
    logic        hit;
    logic        ev;
    logic [11:0] ev_tag;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic rd_chk(input logic [2:0] s, input logic [2:0] w, input logic [11:0] t,
                        input logic v, input logic d);
    rd_index = s;
    rd_way   = w;
    #1;
    if (v) chk($sformatf("rd_tag[%0d][%0d]", s, w), {20'd0, rd_tag}, {20'd0, t});
    chk($sformatf("rd_valid[%0d][%0d]", s, w), {31'd0, rd_valid}, {31'd0, v});
    chk($sformatf("rd_dirty[%0d][%0d]", s, w), {31'd0, rd_dirty}, {31'd0, d});
  endtask

  // Counts valid and dirty bits across the given set range; both must be zero.
  task automatic sweep_empty(input string name, input int s_lo, input int s_hi);
    int nv = 0;
    int nd = 0;
    for (int s = s_lo; s <= s_hi; s++) begin
      for (int w = 0; w < 8; w++) begin
        rd_index = 3'(s);
        rd_way   = 3'(w);
        #1;
        nv += int'(rd_valid);
        nd += int'(rd_dirty);
      end
    end
    chk({name, "_valid_count"}, 32'(nv), 32'd0);
    chk({name, "_dirty_count"}, 32'(nd), 32'd0);
    $display("sweep %s sets %0d..%0d: valid=%0d dirty=%0d", name, s_lo, s_hi, nv, nd);
  endtask

  task automatic do_write(input vec_t v, input string name);
    int  lat = 0;
    bit  got = 0;
    @(negedge clk);
    chk({name, "_ready"}, {31'd0, wr_ready}, 32'd1);
    wr_req   = 1'b1;
    wr_index = v.idx;
    wr_tag   = v.tag;
    wr_dirty = v.dirty;
    while (!got && lat < 20) begin
      @(negedge clk);
      if (lat == 0) wr_req = 1'b0;
      lat++;
      if (wr_ack) got = 1;
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: no wr_ack within 20 cycles, expected at %0d", name, v.lat);
      return;
    end
    $display("%s idx=%0d tag=%03h dirty=%0d -> lat=%0d way=%0d hit=%0d ev=%0d ev_tag=%03h",
             name, v.idx, v.tag, v.dirty, lat, wr_way, wr_hit, evict_valid, evict_tag);
    chk({name, "_latency"}, 32'(lat), 32'(v.lat));
    chk({name, "_way"}, {29'd0, wr_way}, {29'd0, v.way});
    chk({name, "_hit"}, {31'd0, wr_hit}, {31'd0, v.hit});
    chk({name, "_evict_valid"}, {31'd0, evict_valid}, {31'd0, v.ev});
    if (v.ev) chk({name, "_evict_tag"}, {20'd0, evict_tag}, {20'd0, v.ev_tag});
    @(negedge clk);
    chk({name, "_ack_pulse"}, {31'd0, wr_ack}, 32'd0);
    chk({name, "_ready_after"}, {31'd0, wr_ready}, 32'd1);
  endtask

  initial begin
    int acks;
    int ack_cyc;

    //              idx  tag      d  way  hit ev ev_tag  lat
    vecs[0]  = '{3'd2, 12'h123, 1'b0, 3'd0, 1'b0, 1'b0, 12'h000, 9};
    vecs[1]  = '{3'd2, 12'h123, 1'b1, 3'd0, 1'b1, 1'b0, 12'h000, 2};
    for (int i = 1; i < 8; i++)
      vecs[1+i] = '{3'd2, 12'h200 + 12'(i), 1'b1, 3'(i), 1'b0, 1'b0, 12'h000, 9};
    vecs[9]  = '{3'd2, 12'h7FF, 1'b1, 3'd0, 1'b0, 1'b1, 12'h123, 9};
    vecs[10] = '{3'd2, 12'h204, 1'b0, 3'd4, 1'b1, 1'b0, 12'h000, 6};
    vecs[11] = '{3'd2, 12'h300, 1'b0, 3'd2, 1'b0, 1'b1, 12'h202, 9};
    vecs[12] = '{3'd2, 12'h301, 1'b1, 3'd6, 1'b0, 1'b1, 12'h206, 9};
    vecs[13] = '{3'd7, 12'hABC, 1'b1, 3'd0, 1'b0, 1'b0, 12'h000, 9};
    vecs[14] = '{3'd7, 12'hABC, 1'b0, 3'd0, 1'b1, 1'b0, 12'h000, 2};
    vecs[15] = '{3'd2, 12'h207, 1'b0, 3'd7, 1'b1, 1'b0, 12'h000, 9};

    rstb = 1'b0; wr_req = 1'b0; wr_index = '0; wr_tag = '0; wr_dirty = 1'b0;
    rd_index = '0; rd_way = '0;
    repeat (3) @(negedge clk);
    chk("reset_wr_ack", {31'd0, wr_ack}, 32'd0);
    chk("reset_evict_valid", {31'd0, evict_valid}, 32'd0);
    rstb = 1'b1;
    @(negedge clk);
    chk("reset_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("reset_wr_way", {29'd0, wr_way}, 32'd0);
    chk("reset_evict_tag", {20'd0, evict_tag}, 32'd0);
    sweep_empty("reset", 0, 7);

    for (int i = 0; i < 16; i++) do_write(vecs[i], $sformatf("vec%0d", i));

    rd_chk(3'd2, 3'd0, 12'h7FF, 1'b1, 1'b1);
    rd_chk(3'd2, 3'd2, 12'h300, 1'b1, 1'b0);
    rd_chk(3'd2, 3'd4, 12'h204, 1'b1, 1'b1);
    rd_chk(3'd2, 3'd6, 12'h301, 1'b1, 1'b1);
    rd_chk(3'd2, 3'd7, 12'h207, 1'b1, 1'b1);
    rd_chk(3'd7, 3'd0, 12'hABC, 1'b1, 1'b1);
    rd_chk(3'd7, 3'd1, 12'h000, 1'b0, 1'b0);
`ifdef CACHE_WRITER_STATS_EN
    chk("stat_hits", {16'd0, stat_hits}, 32'd4);
    chk("stat_allocs", {16'd0, stat_allocs}, 32'd12);
    chk("stat_evicts", {16'd0, stat_evicts}, 32'd3);
`endif

    // Requests presented while busy must be dropped, not queued.
    @(negedge clk);
    chk("busy_ready", {31'd0, wr_ready}, 32'd1);
    wr_req = 1'b1; wr_index = 3'd5; wr_tag = 12'h055; wr_dirty = 1'b1;
    acks = 0; ack_cyc = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      wr_req = (c == 2 || c == 4);
      if (c == 2) begin wr_index = 3'd6; wr_tag = 12'h066; wr_dirty = 1'b1; end
      if (wr_ack) begin acks++; ack_cyc = c; end
    end
    $display("busy test: acks=%0d at cycle %0d", acks, ack_cyc);
    chk("busy_ack_count", 32'(acks), 32'd1);
    chk("busy_ack_cycle", 32'(ack_cyc), 32'd9);
    sweep_empty("busy_set6", 6, 6);
    rd_chk(3'd5, 3'd0, 12'h055, 1'b1, 1'b1);

    // Reset in the middle of a scan discards the request and clears the array.
    @(negedge clk);
    wr_req = 1'b1; wr_index = 3'd3; wr_tag = 12'h033; wr_dirty = 1'b1;
    @(negedge clk);
    wr_req = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b0;
    #1;
    chk("midreset_ack_low", {31'd0, wr_ack}, 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    acks = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (wr_ack) acks++;
    end
    $display("midreset test: acks after reset=%0d", acks);
    chk("midreset_no_ack", 32'(acks), 32'd0);
    sweep_empty("midreset", 0, 7);
    do_write('{3'd2, 12'h0AA, 1'b0, 3'd0, 1'b0, 1'b0, 12'h000, 9}, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
